reg_write_arbiter: RTL and testbench

- Controller that shares one WIDTH-bit synchronous-reset/load register among N requesters.
- Arbitrates write requests round-robin and drives the register's load enable and data.
- Issues clear commands on the register's synchronous reset input.
- Reads back the register output after each write, then acknowledges the requester with the read-back value and a mismatch flag.

---
 rtl/reg_write_arbiter.sv | 105 ++++++++++
 tb/tb_reg_write_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin write/clear controller for one shared WIDTH-bit load/reset register.
// Latency: req seen in IDLE -> LOAD -> CHECK (ack) = 2 cycles, then GAP idle cycles.
// Backpressure: req/clr_req are held by the requester until ack/clr_done; nothing is sampled outside IDLE.
module reg_write_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   wdata,
    input  logic                 clr_req,
    input  logic [WIDTH-1:0]     reg_q,
    output logic [WIDTH-1:0]     reg_d,
    output logic                 reg_en,
    output logic                 reg_rst,
    output logic [N-1:0]         grant,
    output logic [N-1:0]         ack,
    output logic                 clr_done,
    output logic [WIDTH-1:0]     rdata,
    output logic                 mismatch,
    output logic                 busy
);
    localparam int PW  = (N > 1) ? $clog2(N) : 1;
    localparam int GM1 = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, CHECK, GAPS} state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     pick;
    logic [PW-1:0]     idx;
    logic              pick_vld;
    logic [WIDTH-1:0]  data;
    logic              is_clr;
    logic [3:0]        gcnt;

    // Scan from farthest to nearest so the first set bit after ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = '0;
        for (int k = N; k >= 1; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= PW'(N - 1);
            grant  <= '0;
            data   <= '0;
            is_clr <= 1'b0;
            gcnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state  <= CLEAR;
                        is_clr <= 1'b1;
                        grant  <= '0;
                    end else if (pick_vld) begin
                        state  <= LOAD;
                        is_clr <= 1'b0;
                        grant  <= {{(N-1){1'b0}}, 1'b1} << pick;
                        data   <= wdata[pick*WIDTH +: WIDTH];
                        ptr    <= pick;
                    end
                end
                LOAD:  state <= CHECK;
                CLEAR: state <= CHECK;
                CHECK: begin
                    grant <= '0;
                    if (GAP > 0) begin
                        state <= GAPS;
                        gcnt  <= 4'(GM1);
                    end else begin
                        state <= IDLE;
                    end
                end
                GAPS: begin
                    if (gcnt == 4'd0) state <= IDLE;
                    else              gcnt  <= gcnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes come only from state; read-back is taken live from reg_q during CHECK.
    assign busy     = (state != IDLE);
    assign reg_en   = (state == LOAD);
    assign reg_rst  = (state == CLEAR);
    assign reg_d    = reg_en ? data : '0;
    assign ack      = (state == CHECK && !is_clr) ? grant : '0;
    assign clr_done = (state == CHECK) && is_clr;
    assign rdata    = (state == CHECK) ? reg_q : '0;
    assign mismatch = (state == CHECK) && (reg_q != (is_clr ? '0 : data));
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized bench for reg_write_arbiter with a transaction-level model and scoreboard.
module tb_reg_write_arbiter;
    localparam int N   = 4;
    localparam int W   = 4;
    localparam int GAP = 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] wdata = '0;
    logic           clr_req = 1'b0;
    logic [W-1:0]   reg_q, reg_d, rdata;
    logic           reg_en, reg_rst, clr_done, mismatch, busy;
    logic [N-1:0]   grant, ack;

    logic [W-1:0]   regm = '0;
    logic [W-1:0]   force_val = '0;
    int             force_cyc = -1;
    int             cyc = 0;
    int             rst_chk = -1;
    int             checks = 0;
    int             errors = 0;
    bit             force_ena = 1'b0;
    bit             keep_clr = 1'b0;
    bit             rand_on = 1'b0;

    typedef struct {
        bit          clr;
        int          id;
        logic [W-1:0] data;
        logic [W-1:0] exp_rdata;
        bit          exp_mis;
        int          stamp;
    } txn_t;

    txn_t sbq[$];
    int   m_last = N - 1;
    int   m_free = 0;
    int   m_i;

    always #5 clk = ~clk;

    reg_write_arbiter #(.N(N), .WIDTH(W), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .clr_req(clr_req),
        .reg_q(reg_q), .reg_d(reg_d), .reg_en(reg_en), .reg_rst(reg_rst),
        .grant(grant), .ack(ack), .clr_done(clr_done), .rdata(rdata),
        .mismatch(mismatch), .busy(busy)
    );

    // The shared register itself, with an optional corrupted read-back in one cycle.
    always @(posedge clk) begin
        if (reg_rst)     regm <= '0;
        else if (reg_en) regm <= reg_d;
    end
    assign reg_q = (cyc == force_cyc) ? force_val : regm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: a transaction starts whenever the controller is free and someone asks.
    always @(posedge clk) begin
        txn_t t;
        if (rst) begin
            m_last    = N - 1;
            m_free    = cyc + 1;
            force_cyc = -1;
            rst_chk   = cyc + 1;
            sbq.delete();
        end else if (cyc >= m_free && (clr_req || req != '0)) begin
            t.clr   = clr_req;
            t.id    = 0;
            t.data  = '0;
            t.stamp = cyc + 2;
            if (!clr_req) begin
                for (int k = 1; k <= N; k++) begin
                    m_i = (m_last + k) % N;
                    if (req[m_i]) begin
                        t.id = m_i;
                        break;
                    end
                end
                m_last = t.id;
                t.data = wdata[t.id*W +: W];
            end
            t.exp_rdata = t.data;
            if (force_ena && $urandom_range(0, 3) == 0) begin
                force_val   = W'($urandom);
                force_cyc   = t.stamp;
                t.exp_rdata = force_val;
            end
            t.exp_mis = (t.exp_rdata != t.data);
            sbq.push_back(t);
            m_free = cyc + 3 + GAP;
        end
        cyc++;
    end

    // Monitor: compares DUT strobes and read-back against the front of the scoreboard.
    always @(negedge clk) begin
        txn_t         f;
        bit           have;
        logic [N-1:0] oh;
        logic [1:0]   le;
        logic [N:0]   de;
        have = (sbq.size() > 0);
        oh   = '0;
        if (have) begin
            f = sbq[0];
            if (!f.clr) oh[f.id] = 1'b1;
        end
        chk("inv_en_rst", 32'(reg_en & reg_rst), 32'd0);
        chk("inv_grant_onehot", 32'($onehot0(grant)), 32'd1);
        chk("inv_ack_in_grant", 32'(ack & ~grant), 32'd0);
        if (cyc == rst_chk)
            chk("reset_outputs", 32'({grant, ack, clr_done, reg_en, reg_rst, reg_d, rdata, mismatch, busy}), 32'd0);
        le = 2'b00;
        if (have && cyc == f.stamp - 1) le = f.clr ? 2'b01 : 2'b10;
        if (le != 2'b00 || reg_en || reg_rst) begin
            chk("load_strobe", 32'({reg_en, reg_rst}), 32'(le));
            if (le != 2'b00) begin
                chk("load_grant", 32'(grant), 32'(oh));
                chk("load_busy", 32'(busy), 32'd1);
                if (!f.clr) chk("load_data", 32'(reg_d), 32'(f.data));
            end
        end
        de = '0;
        if (have && cyc == f.stamp) de = f.clr ? (N+1)'(1) : {oh, 1'b0};
        if (de != '0 || ack != '0 || clr_done) begin
            chk("done_strobe", 32'({ack, clr_done}), 32'(de));
            if (de != '0) begin
                chk("done_rdata", 32'(rdata), 32'(f.exp_rdata));
                chk("done_mismatch", 32'(mismatch), 32'(f.exp_mis));
                chk("done_busy", 32'(busy), 32'd1);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) if (ack[i]) req[i] = 1'b0;
        if (clr_done) begin
            if (keep_clr) keep_clr = 1'b0;
            else          clr_req  = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((req != '0 || clr_req || busy) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: still busy after %0d cycles", budget);
            req = '0;
            clr_req = 1'b0;
        end
    endtask

    task automatic wait_en(input int budget);
        int n = 0;
        while (!reg_en && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: no reg_en within %0d cycles", budget);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        do_reset();
        // Single write from requester 0.
        wdata[3:0] = 4'b0101;
        req = 4'b0001;
        wait_idle(50);
        // All four continuously requesting from a fresh pointer.
        do_reset();
        wdata = {4'b1100, 4'b0110, 4'b0011, 4'b1001};
        req = 4'b1111;
        wait_idle(100);
        // Clear and write requested together.
        clr_req = 1'b1;
        wdata[7:4] = 4'b0111;
        req = 4'b0010;
        wait_idle(50);
        // Reset while a write is loading; requester 0 must win afterwards.
        req = 4'b0011;
        wait_en(20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_idle(50);
        // Request withdrawn after grant still completes.
        wdata[11:8] = 4'b1010;
        req = 4'b0100;
        wait_en(20);
        req[2] = 1'b0;
        wait_idle(50);
        // Randomized traffic with occasional corrupted read-back, clears and resets.
        force_ena = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 5) == 0) begin
                    wdata[i*W +: W] = W'($urandom);
                    req[i] = 1'b1;
                end
            end
            if (reg_en && grant != '0 && $urandom_range(0, 7) == 0) req = req & ~grant;
            if (!clr_req && $urandom_range(0, 29) == 0) begin
                clr_req  = 1'b1;
                keep_clr = ($urandom_range(0, 2) == 0);
            end
            rst = reg_en && ($urandom_range(0, 39) == 0);
        end
        rst = 1'b0;
        force_ena = 1'b0;
        wait_idle(200);
        step();
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
